// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- UART transmitter
//
// Serialises one byte per frame, LSB first:
//   start (0) | DATA_WIDTH data bits | optional parity | stop (1)
// Each bit lasts P clk cycles, where P is the prescale value captured when the
// byte is accepted (0 is treated as 1). A byte offered on the final stop cycle
// is accepted back-to-back, so the next start bit follows with no idle gap.
//
// Ports
//   clk        : transmit clock, rising edge
//   rst        : asynchronous active-low reset
//   p_data     : byte to send, captured on accept
//   data_valid : send request, honoured only in IDLE or on the final stop cycle
//   par_en     : 1 = append a parity bit (captured on accept)
//   par_typ    : 0 = even, 1 = odd parity (captured on accept)
//   prescale   : clk cycles per bit (captured on accept, 0 -> 1)
//   tx_out     : serial line, registered, idles high
//   busy       : registered, high while a frame is in progress
//   data_ack   : registered one-cycle pulse in the cycle after an accept
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  data_ack
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // State and counters
  logic [2:0]            r_state;
  logic [PRESCALE_W-1:0] r_cnt;
  logic [BCW-1:0]        r_bit_cnt;

  // Frame shadow registers, constant from accept to end of frame
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic [PRESCALE_W-1:0] r_prescale;

  // Registered outputs
  logic                  r_tx_out;
  logic                  r_busy;
  logic                  r_data_ack;

  // Next-state signals
  logic                  w_bit_end;
  logic                  w_accept;
  logic [BCW-1:0]        w_bit_nxt;
  logic [DATA_WIDTH-1:0] w_data_sh;
  logic [2:0]            w_state_nxt;
  logic [PRESCALE_W-1:0] w_cnt_nxt;
  logic [BCW-1:0]        w_bit_cnt_nxt;
  logic                  w_tx_nxt;

  always_comb begin
    w_bit_end     = (r_cnt == r_prescale - PRESCALE_W'(1));
    // A request is honoured when idle or on the very last stop cycle, which
    // makes back-to-back frames abut with exactly one stop bit.
    w_accept      = data_valid && ((r_state == S_IDLE) ||
                                   ((r_state == S_STOP) && w_bit_end));
    w_bit_nxt     = r_bit_cnt + BCW'(1);
    w_data_sh     = r_data >> w_bit_nxt;

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    w_state_nxt   = r_state;
    w_cnt_nxt     = w_bit_end ? '0 : r_cnt + PRESCALE_W'(1);
    w_bit_cnt_nxt = r_bit_cnt;
    w_tx_nxt      = r_tx_out;

    // tx_out is registered, so it is loaded with the level of the bit being
    // entered at each boundary rather than the one being left.
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_tx_nxt  = 1'b1;
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt   = S_DATA;
          w_bit_cnt_nxt = '0;
          w_tx_nxt      = r_data[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            w_tx_nxt    = r_par_en ? r_par_bit : 1'b1;
          end else begin
            w_bit_cnt_nxt = w_bit_nxt;
            w_tx_nxt      = w_data_sh[0];
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
          w_tx_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase

    if (w_accept) begin
      w_state_nxt   = S_START;
      w_cnt_nxt     = '0;
      w_bit_cnt_nxt = '0;
      w_tx_nxt      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit_cnt  <= '0;
      r_tx_out   <= 1'b1;
      r_busy     <= 1'b0;
      r_data_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_tx_out   <= w_tx_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_data_ack <= w_accept;
    end
  end

  // NOTE: the shadow registers are cleared on reset too, so no stale frame
  // parameters survive a mid-frame reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_prescale <= '0;
    end else if (w_accept) begin
      r_data     <= p_data;
      r_par_en   <= par_en;
      // Even parity is the XOR of the data bits; odd parity inverts it.
      r_par_bit  <= (^p_data) ^ par_typ;
      r_prescale <= (prescale == '0) ? PRESCALE_W'(1) : prescale;
    end
  end

  assign tx_out   = r_tx_out;
  assign busy     = r_busy;
  assign data_ack = r_data_ack;

endmodule
